imem_loader: RTL and testbench

- Boot-time writer for the instruction memory. It receives a byte stream over a valid/ready handshake and assembles each group of 4 bytes into a 32-bit instruction, MSB byte first.
- It writes the assembled words into consecutive imem addresses starting at 0.
- It holds the processor in reset until the programmed word count has been loaded.
- It sits between the external boot source and the imem write port, opposite the fetch-side read port (a, rd).

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a valid/ready byte stream MSB-first into
// words, writes them to consecutive imem addresses and holds the CPU in reset until done.
module imem_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_reset
);

    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned BYTES    = DATA_W / 8;
    localparam int unsigned IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned LAST_IDX = BYTES - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;

    logic                byte_ready_q, byte_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cpu_reset_q, cpu_reset_d;

    logic                start_ok;

    assign start_ok = (word_count != '0) && (word_count <= CNT_W'(DEPTH));

    // Next-state and next-output decode; outputs are derived from the next state
    // so that every output register lines up with the state register.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (start_ok) begin
                        count_d = word_count;
                        words_d = '0;
                        addr_d  = '0;
                        idx_d   = '0;
                        state_d = S_RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RECV: begin
                // byte_ready is high for every cycle spent in RECV
                if (byte_valid && byte_ready_q) begin
                    shreg_d = {shreg_q[DATA_W-9:0], byte_in};
                    idx_d   = IDX_W'(idx_q + IDX_W'(1));
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        we_d    = 1'b1;
                        wa_d    = addr_q;
                        wd_d    = shreg_d;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = ADDR_W'(addr_q + ADDR_W'(1));
                words_d = CNT_W'(words_q + CNT_W'(1));
                idx_d   = '0;
                if (CNT_W'(words_q + CNT_W'(1)) == count_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_RECV);
        busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        cpu_reset_d  = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            words_q      <= '0;
            addr_q       <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            words_q      <= words_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            byte_ready_q <= byte_ready_d;
            we_q         <= we_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign we         = we_q;
    assign wa         = wa_q;
    assign wd         = wd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_reset  = cpu_reset_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; inputs change and outputs are
// sampled on the falling clock edge.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_reset;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];
    int                ready_on_write = 0;
    int                busy_cycles    = 0;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_reset  (cpu_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor
    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(wa);
            wr_data.push_back(wd);
            if (byte_ready) ready_on_write++;
        end
        if (busy) busy_cycles++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; word_count = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        ready_on_write = 0;
    endtask

    task automatic start_load(input logic [ADDR_W:0] cnt);
        start = 1'b1; word_count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1; byte_in = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte: byte_ready never asserted for byte %02h", b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: done not reached, done=%b required 1", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; word_count = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({byte_ready, we, wa, wd, busy, done, err, cpu_reset} !==
            {1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: br=%b we=%b wa=%0d wd=%h busy=%b done=%b err=%b cpu_reset=%b required 0 0 0 0 0 0 0 1",
                     byte_ready, we, wa, wd, busy, done, err, cpu_reset);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] b;
        do_reset();
        start_load(7'd4);
        n_checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start: busy=%b byte_ready=%b cpu_reset=%b required 1 1 1", busy, byte_ready, cpu_reset);
        end
        for (int w = 0; w < 4; w++) begin
            b = 8'(w * 8'h11);
            for (int k = 0; k < 4; k++) send_byte(b, 0);
        end
        n_checks++;
        if (we !== 1'b1 || wa !== 6'd3 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_last_write: we=%b wa=%0d byte_ready=%b required 1 3 0", we, wa, byte_ready);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b cpu_reset=%b busy=%b we=%b required 1 0 0 0", done, cpu_reset, busy, we);
        end
        n_checks++;
        if (wr_addr.size() !== 4) begin
            n_fail++;
            $display("FAIL basic_count: writes=%0d required 4", wr_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_addr[i] !== 6'(i) || wr_data[i] !== {4{8'(i * 8'h11)}}) begin
                    n_fail++;
                    $display("FAIL basic_word%0d: wa=%0d wd=%h required %0d %h", i, wr_addr[i], wr_data[i], i, {4{8'(i * 8'h11)}});
                end
            end
        end
        n_checks++;
        if (ready_on_write !== 0) begin
            n_fail++;
            $display("FAIL basic_ready_on_write: count=%0d required 0", ready_on_write);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || wa !== 6'd3 || wd !== 32'h33333333) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b wa=%0d wd=%h required 1 3 33333333", done, wa, wd);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        start_load(7'd1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 2);
        send_byte(8'hBE, 2);
        send_byte(8'hEF, 2);
        wait_done("backpressure_done");
        n_checks++;
        if (wr_addr.size() !== 1) begin
            n_fail++;
            $display("FAIL backpressure_count: writes=%0d required 1", wr_addr.size());
        end else begin
            n_checks++;
            if (wr_addr[0] !== 6'd0 || wr_data[0] !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL backpressure_word: wa=%0d wd=%h required 0 deadbeef", wr_addr[0], wr_data[0]);
            end
        end
    endtask

    task automatic test_illegal_count();
        logic [ADDR_W:0] bad [2];
        bad[0] = 7'd0;
        bad[1] = 7'd65;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            start_load(bad[i]);
            n_checks++;
            if (err !== 1'b1 || busy !== 1'b0 || we !== 1'b0 || cpu_reset !== 1'b1 || byte_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_%0d: err=%b busy=%b we=%b cpu_reset=%b byte_ready=%b required 1 0 0 1 0",
                         bad[i], err, busy, we, cpu_reset, byte_ready);
            end
            @(negedge clk);
            n_checks++;
            if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_%0d_after: err=%b busy=%b done=%b required 0 0 0", bad[i], err, busy, done);
            end
        end
    endtask

    task automatic test_full_depth();
        do_reset();
        busy_cycles = 0;
        start_load(7'd64);
        for (int w = 0; w < 64; w++) begin
            send_byte(8'h00, 0);
            send_byte(8'h00, 0);
            send_byte(8'h00, 0);
            send_byte(8'(w), 0);
        end
        wait_done("full_done");
        n_checks++;
        if (busy_cycles !== 320) begin
            n_fail++;
            $display("FAIL full_cycles: busy cycles=%0d required 320", busy_cycles);
        end
        n_checks++;
        if (wr_addr.size() !== 64) begin
            n_fail++;
            $display("FAIL full_count: writes=%0d required 64", wr_addr.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                n_checks++;
                if (wr_addr[i] !== 6'(i) || wr_data[i] !== 32'(i)) begin
                    n_fail++;
                    $display("FAIL full_word%0d: wa=%0d wd=%h required %0d %h", i, wr_addr[i], wr_data[i], i, 32'(i));
                end
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_addr.size() !== 64 || wa !== 6'd63 || wd !== 32'h3F) begin
            n_fail++;
            $display("FAIL full_nowrap: writes=%0d wa=%0d wd=%h required 64 63 3f", wr_addr.size(), wa, wd);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        start_load(7'd4);
        send_byte(8'hA0, 0); send_byte(8'hA1, 0); send_byte(8'hA2, 0); send_byte(8'hA3, 0);
        send_byte(8'hB0, 0); send_byte(8'hB1, 0);
        reset = 1'b1;
        byte_valid = 1'b1; byte_in = 8'hB2;
        @(negedge clk);
        n_checks++;
        if ({byte_ready, we, wa, wd, busy, done, err, cpu_reset} !==
            {1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_values: br=%b we=%b wa=%0d wd=%h busy=%b done=%b err=%b cpu_reset=%b required 0 0 0 0 0 0 0 1",
                     byte_ready, we, wa, wd, busy, done, err, cpu_reset);
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        n_checks++;
        if (wr_addr.size() !== 1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_quiet: writes=%0d busy=%b byte_ready=%b required 1 0 0", wr_addr.size(), busy, byte_ready);
        end
        start_load(7'd1);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
        wait_done("midreset_reload_done");
        n_checks++;
        if (wr_addr.size() !== 2) begin
            n_fail++;
            $display("FAIL midreset_count: writes=%0d required 2", wr_addr.size());
        end else begin
            n_checks++;
            if (wr_addr[1] !== 6'd0 || wr_data[1] !== 32'h12345678) begin
                n_fail++;
                $display("FAIL midreset_word: wa=%0d wd=%h required 0 12345678", wr_addr[1], wr_data[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_load(7'd2);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        start_load(7'd1);
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b0 || byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start: busy=%b err=%b byte_ready=%b required 1 0 1", busy, err, byte_ready);
        end
        send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
        wait_done("b2b_done");
        n_checks++;
        if (wr_addr.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: writes=%0d required 2", wr_addr.size());
        end else begin
            n_checks++;
            if (wr_data[0] !== 32'h01020304 || wr_data[1] !== 32'h05060708 || wr_addr[1] !== 6'd1) begin
                n_fail++;
                $display("FAIL b2b_words: wd0=%h wd1=%h wa1=%0d required 01020304 05060708 1", wr_data[0], wr_data[1], wr_addr[1]);
            end
        end
        start_load(7'd0);
        n_checks++;
        if (err !== 1'b1 || done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_reject: err=%b done=%b cpu_reset=%b busy=%b required 1 1 0 0", err, done, cpu_reset, busy);
        end
        @(negedge clk);
        start_load(7'd1);
        n_checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_start: cpu_reset=%b done=%b busy=%b err=%b required 1 0 1 0", cpu_reset, done, busy, err);
        end
        send_byte(8'hCA, 0); send_byte(8'hFE, 1); send_byte(8'hF0, 0); send_byte(8'h0D, 0);
        wait_done("reload_done");
        n_checks++;
        if (wr_addr.size() !== 3) begin
            n_fail++;
            $display("FAIL reload_count: writes=%0d required 3", wr_addr.size());
        end else begin
            n_checks++;
            if (wr_addr[2] !== 6'd0 || wr_data[2] !== 32'hCAFEF00D || cpu_reset !== 1'b0) begin
                n_fail++;
                $display("FAIL reload_word: wa=%0d wd=%h cpu_reset=%b required 0 cafef00d 0", wr_addr[2], wr_data[2], cpu_reset);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; word_count = '0; byte_in = 8'h00; byte_valid = 1'b0;
        test_reset();
        test_basic();
        test_back_pressure();
        test_illegal_count();
        test_full_depth();
        test_reset_mid_load();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
